// File: rtl/w5500_pkg.sv
// Shared types and constants for building W5500 variable-length SPI frames.
// The control byte packs block select, read/write and the operating mode.
package w5500_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_WDATA,
      ST_START,
      ST_WAIT_BUSY,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } frame_state_t;

   localparam int         HDR_LEN  = 3;
   localparam logic [1:0] OM_VDM   = 2'b00;
   localparam logic       RW_WRITE = 1'b1;

   function automatic logic [7:0] w5500_ctrl(input logic [4:0] bsb, input logic rw);
      return {bsb, rw, OM_VDM};
   endfunction

endpackage

// File: rtl/w5500_frame_master.sv
// Turns a request (address, block, direction, length) into one W5500 SPI frame:
// fills the TX FIFO, kicks spi_interface, and streams read bytes back from the RX FIFO.
module w5500_frame_master
   import w5500_pkg::*;
#(
   parameter int DATA         = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [15:0]     req_addr,
   input  logic [4:0]      req_bsb,
   input  logic            req_rw,
   input  logic [15:0]     req_len,
   input  logic [DATA-1:0] wd_data,
   input  logic            wd_valid,
   output logic            wd_ready,
   output logic [DATA-1:0] rd_data,
   output logic            rd_valid,
   output logic            done,
   output logic            err,
   output logic [DATA-1:0] wdata,
   output logic            wr,
   input  logic            full,
   input  logic [DATA-1:0] rdata,
   output logic            rd,
   input  logic            empty,
   output logic [15:0]     len,
   output logic            op,
   output logic            work,
   input  logic            busy
);

   localparam int          TCW   = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [15:0] MAX_N = 16'(FIFO_DEPTH - HDR_LEN);
   localparam logic [15:0] HDR_W = 16'(HDR_LEN);

   frame_state_t    state_reg, state_next;
   logic [15:0]     addr_reg;
   logic [4:0]      bsb_reg;
   logic            rw_reg;
   logic [15:0]     n_reg, l_reg;
   logic [15:0]     byte_cnt_reg, byte_cnt_next;
   logic [15:0]     pop_cnt_reg, pop_cnt_next;
   logic [TCW-1:0]  tcnt_reg, tcnt_next;
   logic            wr_reg, wr_next;
   logic [DATA-1:0] wdata_reg, wdata_next;
   logic            work_reg, work_next;
   logic            done_reg, done_next;
   logic            err_reg, err_next;
   logic            rd_reg, rd_next;
   logic            keep_reg, keep_next;
   logic            rd_valid_reg;
   logic [15:0]     len_reg;
   logic            op_reg;
   logic [7:0]      hdr_byte;
   logic            req_fire, wd_fire, len_ok, drain_en;

   assign req_ready = (state_reg == ST_IDLE) && !rst;
   assign wd_ready  = (state_reg == ST_WDATA) && !full && !rst;
   assign req_fire  = req_valid && req_ready;
   assign wd_fire   = wd_valid && wd_ready;
   assign len_ok    = (req_len != 16'd0) && (req_len <= MAX_N);

   assign wr       = wr_reg;
   assign wdata    = wdata_reg;
   assign work     = work_reg;
   assign done     = done_reg;
   assign err      = err_reg;
   assign rd       = rd_reg;
   assign rd_valid = rd_valid_reg;
   assign rd_data  = rd_valid_reg ? rdata : '0;
   assign len      = len_reg;
   assign op       = op_reg;

   always_comb begin
      hdr_byte = w5500_ctrl(bsb_reg, rw_reg);
      if (byte_cnt_reg == 16'd0)      hdr_byte = addr_reg[15:8];
      else if (byte_cnt_reg == 16'd1) hdr_byte = addr_reg[7:0];
   end

   // rd is registered, so skip a cycle after each pop to let empty catch up.
   assign drain_en  = (rw_reg != RW_WRITE) &&
                      (state_reg inside {ST_WAIT_BUSY, ST_RUN, ST_DRAIN});
   assign rd_next   = drain_en && !empty && !rd_reg && (pop_cnt_reg < l_reg);
   assign keep_next = rd_next && (pop_cnt_reg >= HDR_W);

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      tcnt_next     = tcnt_reg;
      wr_next       = 1'b0;
      wdata_next    = wdata_reg;
      err_next      = 1'b0;
      pop_cnt_next  = rd_next ? pop_cnt_reg + 16'd1 : pop_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_fire) begin
               byte_cnt_next = 16'd0;
               if (len_ok) begin
                  state_next = ST_HDR;
               end else begin
                  state_next = ST_DONE;
                  err_next   = 1'b1;
               end
            end
         end
         ST_HDR: begin
            if (!full) begin
               wr_next    = 1'b1;
               wdata_next = DATA'(hdr_byte);
               if (byte_cnt_reg == HDR_W - 16'd1) begin
                  byte_cnt_next = 16'd0;
                  state_next    = (rw_reg == RW_WRITE) ? ST_WDATA : ST_START;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 16'd1;
               end
            end
         end
         ST_WDATA: begin
            if (wd_fire) begin
               wr_next    = 1'b1;
               wdata_next = wd_data;
               if (byte_cnt_reg == n_reg - 16'd1) begin
                  byte_cnt_next = 16'd0;
                  state_next    = ST_START;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 16'd1;
               end
            end
         end
         ST_START: begin
            tcnt_next    = TCW'(1);
            pop_cnt_next = 16'd0;
            state_next   = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            // Counts cycles since work; expiring lands DONE exactly BUSY_TIMEOUT after it.
            if (busy) begin
               state_next = ST_RUN;
            end else if (tcnt_reg == TCW'(BUSY_TIMEOUT - 1)) begin
               state_next = ST_DONE;
               err_next   = 1'b1;
            end else begin
               tcnt_next = tcnt_reg + TCW'(1);
            end
         end
         ST_RUN: begin
            if (!busy) state_next = (rw_reg == RW_WRITE) ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((pop_cnt_reg == l_reg) && !rd_reg && !keep_reg) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign work_next = (state_next == ST_START);
   assign done_next = (state_next == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         addr_reg     <= '0;
         bsb_reg      <= '0;
         rw_reg       <= 1'b0;
         n_reg        <= '0;
         l_reg        <= '0;
         byte_cnt_reg <= '0;
         pop_cnt_reg  <= '0;
         tcnt_reg     <= '0;
         wr_reg       <= 1'b0;
         wdata_reg    <= '0;
         work_reg     <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         rd_reg       <= 1'b0;
         keep_reg     <= 1'b0;
         rd_valid_reg <= 1'b0;
         len_reg      <= '0;
         op_reg       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         pop_cnt_reg  <= pop_cnt_next;
         tcnt_reg     <= tcnt_next;
         wr_reg       <= wr_next;
         wdata_reg    <= wdata_next;
         work_reg     <= work_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         rd_reg       <= rd_next;
         keep_reg     <= keep_next;
         rd_valid_reg <= keep_reg;
         if (req_fire) begin
            addr_reg <= req_addr;
            bsb_reg  <= req_bsb;
            rw_reg   <= req_rw;
            n_reg    <= req_len;
            l_reg    <= req_len + HDR_W;
         end
         if (state_next == ST_START) begin
            len_reg <= l_reg;
            op_reg  <= rw_reg;
         end else if (state_reg == ST_DONE) begin
            len_reg <= '0;
            op_reg  <= 1'b0;
         end
      end
   end

endmodule
